rtc_write_sequencer: RTL and testbench
======================================

// Module: rtc_write_sequencer
// PURPOSE
//  Write-side counterpart of the RTC read sequencer: on an Escritura request it stages clock/date or
//  timer values into RTC RAM, one register per step, and then issues the RAM->clock/timer transfer command.
//  Bus timing comes from the control machine's DIR/DAT/cambio_estado strobes. This block supplies the
//  address/data byte and handshake flags back to the main and control machines.
// PARAMETERS
//  A_SEG_C   8'h21  clock seconds RAM address (A_MIN_C 8'h22, A_HORA_C 8'h23)
//  A_DIA     8'h24  day address (A_MES 8'h25, A_ANO 8'h26)
//  A_SEG_T   8'h41  timer seconds address (A_MIN_T 8'h42, A_HORA_T 8'h43)
//  CMD_WR_C  8'hF1  command address: RAM -> clock transfer
//  CMD_WR_T  8'hF2  command address: RAM -> timer transfer
//  CMD_DATA  8'h01  data byte sent in the command DAT phase
//  IDLE_BUS  8'hFF  Dir_E value while idle
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-low reset
//  Escritura      in   1  start request from main machine (level or pulse; sampled only in IDLE)
//  En_clk         in   1  1 = clock+date pass, 0 = timer pass; sampled with Escritura
//  DIR            in   1  control-machine strobe: address phase
//  DAT            in   1  control-machine strobe: data phase
//  cambio_estado  in   1  control-machine strobe: current bus cycle finished, advance
//  Seg,Min,Hora   in   8  clock time (BCD) to write
//  Dia,Mes,Ano    in   8  date (BCD) to write
//  Seg_T,Min_T,Hora_T in 8 timer value (BCD) to write
//  Dir_E          out  8  byte driven to RTC bus (address in DIR phase, data in DAT phase)
//  E_Esc          out  1  write engine busy / requesting bus cycles
//  Tr_Esc         out  1  high while the transfer command is on the bus
//  Term_Esc       out  1  one-cycle completion pulse to main machine
//  clk_timerE     out  1  pass type: 0 clock, 1 timer
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0 at posedge) forces IDLE and sets Dir_E=IDLE_BUS.
//    It also clears E_Esc, Tr_Esc, Term_Esc and clk_timerE, plus all shadow registers. This applies mid-pass too.
//  - IDLE: Dir_E=IDLE_BUS, E_Esc=0. When Escritura=1:
//      - snapshot all 9 data inputs into shadow registers (later input changes are ignored);
//      - latch clk_timerE=~En_clk and set E_Esc=1;
//      - go to W_SEG on the next cycle.
//  - Data states W_SEG, W_MIN, W_HORA, then W_DIA, W_MES, W_ANO (clock pass only), then W_CMD:
//      - DIR: Dir_E <= state address (clock or timer set per clk_timerE).
//      - DAT: Dir_E <= shadow value for that state.
//      - cambio_estado: advance and drive E_Esc=0 for exactly one cycle. E_Esc returns to 1 on the next cycle.
//      - Priority DIR > DAT > cambio_estado. No strobe: hold all outputs.
//  - Timer pass: after W_HORA, go straight to W_CMD.
//  - W_CMD:
//      - DIR: Dir_E <= CMD_WR_C or CMD_WR_T.
//      - DAT: Dir_E <= CMD_DATA and Tr_Esc <= 1.
//      - cambio_estado: Tr_Esc <= 0, E_Esc <= 0, then go to DONE.
//  - DONE: Term_Esc=1 for one cycle and Dir_E=IDLE_BUS, then IDLE. A new Escritura is accepted from IDLE only,
//    so minimum gap is one cycle.
//  - Escritura while busy: ignored. A strobe in IDLE/DONE: ignored.
//  - Output latency: 1 clk after the strobe.
//  - Bus cycles per pass: clock 7 (6 regs + cmd), timer 4 (3 regs + cmd).
//  - Unused state encodings: go to IDLE.
// TESTING
//  - Reset: hold reset=0 with strobes active -> Dir_E=8'hFF, E_Esc=0, Tr_Esc=0, Term_Esc=0, clk_timerE=0.
//  - Clock pass, 12:34:56 25/12/16:
//      - stimulus: Escritura=1, En_clk=1, then DIR/DAT/cambio per step;
//      - Dir_E sequence: 21,56,22,34,23,12,24,25,25,12,26,16,F1,01;
//      - Tr_Esc=1 only after the 01 byte; one Term_Esc pulse; clk_timerE=0.
//  - Timer pass 00:05:30 (En_clk=0): Dir_E 41,30,42,05,43,00,F2,01; clk_timerE=1; DIA/MES/ANO skipped.
//  - Snapshot: change Seg 56->59 after start -> DAT byte for 0x21 is still 56. Escritura mid-pass -> no restart.
//  - Priority: DIR and DAT in the same cycle at W_MIN -> Dir_E=22. DAT+cambio together -> data latched, state held.
//  - Reset asserted during W_MES -> next cycle IDLE, Dir_E=FF. A later pass writes 21.. from the start.

Source files
------------

// File: rtl/rtc_write_sequencer.sv
// Write sequencer for the RTC: stages clock/date or timer bytes into RTC RAM one register
// per bus cycle, then issues the RAM->clock/timer transfer command.
module rtc_write_sequencer (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_escritura,
    input  logic       i_en_clk,
    input  logic       i_dir,
    input  logic       i_dat,
    input  logic       i_cambio_estado,
    input  logic [7:0] i_seg,
    input  logic [7:0] i_min,
    input  logic [7:0] i_hora,
    input  logic [7:0] i_dia,
    input  logic [7:0] i_mes,
    input  logic [7:0] i_ano,
    input  logic [7:0] i_seg_t,
    input  logic [7:0] i_min_t,
    input  logic [7:0] i_hora_t,
    output logic [7:0] o_dir_e,
    output logic       o_e_esc,
    output logic       o_tr_esc,
    output logic       o_term_esc,
    output logic       o_clk_timer_e
);

    localparam logic [7:0] A_SEG_C  = 8'h21;
    localparam logic [7:0] A_MIN_C  = 8'h22;
    localparam logic [7:0] A_HORA_C = 8'h23;
    localparam logic [7:0] A_DIA    = 8'h24;
    localparam logic [7:0] A_MES    = 8'h25;
    localparam logic [7:0] A_ANO    = 8'h26;
    localparam logic [7:0] A_SEG_T  = 8'h41;
    localparam logic [7:0] A_MIN_T  = 8'h42;
    localparam logic [7:0] A_HORA_T = 8'h43;
    localparam logic [7:0] CMD_WR_C = 8'hF1;
    localparam logic [7:0] CMD_WR_T = 8'hF2;
    localparam logic [7:0] CMD_DATA = 8'h01;
    localparam logic [7:0] IDLE_BUS = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_SEG, S_MIN, S_HORA, S_DIA, S_MES, S_ANO, S_CMD, S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_dir_e;
    logic       r_e_esc;
    logic       r_tr_esc;
    logic       r_term_esc;
    logic       r_clk_timer_e;
    logic [7:0] r_seg, r_min, r_hora, r_dia, r_mes, r_ano, r_seg_t, r_min_t, r_hora_t;

    logic [7:0] w_addr;
    logic [7:0] w_data;
    state_t     w_next;

    // Address/data of the register handled in the current bus step; the pass type picks the bank.
    always_comb begin
        w_addr = IDLE_BUS;
        w_data = CMD_DATA;
        w_next = S_IDLE;
        case (r_state)
            S_SEG: begin
                w_addr = r_clk_timer_e ? A_SEG_T : A_SEG_C;
                w_data = r_clk_timer_e ? r_seg_t : r_seg;
                w_next = S_MIN;
            end
            S_MIN: begin
                w_addr = r_clk_timer_e ? A_MIN_T : A_MIN_C;
                w_data = r_clk_timer_e ? r_min_t : r_min;
                w_next = S_HORA;
            end
            S_HORA: begin
                w_addr = r_clk_timer_e ? A_HORA_T : A_HORA_C;
                w_data = r_clk_timer_e ? r_hora_t : r_hora;
                w_next = r_clk_timer_e ? S_CMD : S_DIA;
            end
            S_DIA: begin
                w_addr = A_DIA;
                w_data = r_dia;
                w_next = S_MES;
            end
            S_MES: begin
                w_addr = A_MES;
                w_data = r_mes;
                w_next = S_ANO;
            end
            S_ANO: begin
                w_addr = A_ANO;
                w_data = r_ano;
                w_next = S_CMD;
            end
            S_CMD: begin
                w_addr = r_clk_timer_e ? CMD_WR_T : CMD_WR_C;
                w_data = CMD_DATA;
                w_next = S_DONE;
            end
            default: begin
                w_addr = IDLE_BUS;
                w_data = CMD_DATA;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_dir_e       <= IDLE_BUS;
            r_e_esc       <= 1'b0;
            r_tr_esc      <= 1'b0;
            r_term_esc    <= 1'b0;
            r_clk_timer_e <= 1'b0;
            r_seg         <= 8'h00;
            r_min         <= 8'h00;
            r_hora        <= 8'h00;
            r_dia         <= 8'h00;
            r_mes         <= 8'h00;
            r_ano         <= 8'h00;
            r_seg_t       <= 8'h00;
            r_min_t       <= 8'h00;
            r_hora_t      <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dir_e    <= IDLE_BUS;
                    r_e_esc    <= 1'b0;
                    r_tr_esc   <= 1'b0;
                    r_term_esc <= 1'b0;
                    if (i_escritura) begin
                        r_seg         <= i_seg;
                        r_min         <= i_min;
                        r_hora        <= i_hora;
                        r_dia         <= i_dia;
                        r_mes         <= i_mes;
                        r_ano         <= i_ano;
                        r_seg_t       <= i_seg_t;
                        r_min_t       <= i_min_t;
                        r_hora_t      <= i_hora_t;
                        r_clk_timer_e <= ~i_en_clk;
                        r_e_esc       <= 1'b1;
                        r_state       <= S_SEG;
                    end
                end
                S_SEG, S_MIN, S_HORA, S_DIA, S_MES, S_ANO, S_CMD: begin
                    // E_Esc dips for exactly the cycle following an advance.
                    r_e_esc <= 1'b1;
                    if (i_dir) begin
                        r_dir_e <= w_addr;
                    end else if (i_dat) begin
                        r_dir_e <= w_data;
                        if (r_state == S_CMD) r_tr_esc <= 1'b1;
                    end else if (i_cambio_estado) begin
                        r_e_esc  <= 1'b0;
                        r_tr_esc <= 1'b0;
                        r_state  <= w_next;
                    end
                end
                S_DONE: begin
                    r_term_esc <= 1'b1;
                    r_dir_e    <= IDLE_BUS;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_dir_e    <= IDLE_BUS;
                    r_e_esc    <= 1'b0;
                    r_tr_esc   <= 1'b0;
                    r_term_esc <= 1'b0;
                end
            endcase
        end
    end

    assign o_dir_e       = r_dir_e;
    assign o_e_esc       = r_e_esc;
    assign o_tr_esc      = r_tr_esc;
    assign o_term_esc    = r_term_esc;
    assign o_clk_timer_e = r_clk_timer_e;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: a step-list model checked every cycle, plus literal
// bus-byte expectations for clock, timer, snapshot, priority and mid-pass reset cases.
module tb_rtc_write_sequencer;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_escritura = 1'b0, i_en_clk = 1'b0;
    logic       i_dir = 1'b0, i_dat = 1'b0, i_cambio = 1'b0;
    logic [7:0] i_seg = 8'h56, i_min = 8'h34, i_hora = 8'h12;
    logic [7:0] i_dia = 8'h25, i_mes = 8'h12, i_ano = 8'h16;
    logic [7:0] i_seg_t = 8'h30, i_min_t = 8'h05, i_hora_t = 8'h00;
    logic [7:0] o_dir_e;
    logic       o_e_esc, o_tr_esc, o_term_esc, o_clk_timer_e;

    int total = 0;
    int bad = 0;
    int term_pulses = 0;
    logic check_en = 1'b0;

    rtc_write_sequencer dut (
        .i_clk(clk), .i_reset(i_reset), .i_escritura(i_escritura), .i_en_clk(i_en_clk),
        .i_dir(i_dir), .i_dat(i_dat), .i_cambio_estado(i_cambio),
        .i_seg(i_seg), .i_min(i_min), .i_hora(i_hora),
        .i_dia(i_dia), .i_mes(i_mes), .i_ano(i_ano),
        .i_seg_t(i_seg_t), .i_min_t(i_min_t), .i_hora_t(i_hora_t),
        .o_dir_e(o_dir_e), .o_e_esc(o_e_esc), .o_tr_esc(o_tr_esc),
        .o_term_esc(o_term_esc), .o_clk_timer_e(o_clk_timer_e)
    );

    always #5 clk = ~clk;

    // Model: a pass is a list of (address, data) bus steps; the last step is the command.
    logic [7:0] m_addr[7];
    logic [7:0] m_data[7];
    int         m_n = 0, m_step = 0;
    bit         m_busy = 0, m_done = 0;
    logic [7:0] m_dir = 8'hFF;
    logic       m_e = 0, m_tr = 0, m_term = 0, m_ct = 0;

    always @(posedge clk) begin
        if (!i_reset) begin
            m_busy = 0; m_done = 0; m_dir = 8'hFF; m_e = 0; m_tr = 0; m_term = 0; m_ct = 0;
        end else if (m_done) begin
            m_done = 0; m_term = 1; m_dir = 8'hFF;
        end else if (!m_busy) begin
            m_term = 0; m_dir = 8'hFF; m_e = 0; m_tr = 0;
            if (i_escritura) begin
                if (i_en_clk) begin
                    m_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF1};
                    m_data = '{i_seg, i_min, i_hora, i_dia, i_mes, i_ano, 8'h01};
                    m_n = 7;
                end else begin
                    m_addr = '{8'h41, 8'h42, 8'h43, 8'hF2, 8'h00, 8'h00, 8'h00};
                    m_data = '{i_seg_t, i_min_t, i_hora_t, 8'h01, 8'h00, 8'h00, 8'h00};
                    m_n = 4;
                end
                m_ct = ~i_en_clk; m_e = 1; m_busy = 1; m_step = 0;
            end
        end else begin
            m_e = 1;
            if (i_dir) m_dir = m_addr[m_step];
            else if (i_dat) begin
                m_dir = m_data[m_step];
                if (m_step == m_n - 1) m_tr = 1;
            end else if (i_cambio) begin
                m_e = 0;
                if (m_step == m_n - 1) begin
                    m_tr = 0; m_busy = 0; m_done = 1;
                end else m_step++;
            end
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("model dir_e", o_dir_e, m_dir);
            cmp("model e_esc", {7'd0, o_e_esc}, {7'd0, m_e});
            cmp("model tr_esc", {7'd0, o_tr_esc}, {7'd0, m_tr});
            cmp("model term_esc", {7'd0, o_term_esc}, {7'd0, m_term});
            cmp("model clk_timerE", {7'd0, o_clk_timer_e}, {7'd0, m_ct});
            if (o_term_esc === 1'b1) term_pulses++;
        end
    end

    task automatic strobe(input logic d, input logic a, input logic c);
        @(negedge clk);
        i_dir = d; i_dat = a; i_cambio = c;
        @(negedge clk);
        i_dir = 0; i_dat = 0; i_cambio = 0;
    endtask

    task automatic start(input logic en);
        @(negedge clk);
        i_escritura = 1; i_en_clk = en;
        @(negedge clk);
        i_escritura = 0;
    endtask

    logic [7:0] exp_seq[14];

    task automatic run_pass(input int nsteps, input logic ct);
        int p0;
        p0 = term_pulses;
        cmp("lit clk_timerE", {7'd0, o_clk_timer_e}, {7'd0, ct});
        for (int k = 0; k < nsteps; k++) begin
            if (k == 2) i_escritura = 1;
            strobe(1, 0, 0);
            i_escritura = 0;
            cmp("lit addr", o_dir_e, exp_seq[2*k]);
            strobe(0, 1, 0);
            cmp("lit data", o_dir_e, exp_seq[2*k+1]);
            cmp("lit tr_esc", {7'd0, o_tr_esc}, (k == nsteps - 1) ? 8'd1 : 8'd0);
            strobe(0, 0, 1);
            cmp("lit e_esc dip", {7'd0, o_e_esc}, 8'd0);
        end
        @(negedge clk);
        cmp("lit term high", {7'd0, o_term_esc}, 8'd1);
        cmp("lit dir idle", o_dir_e, 8'hFF);
        @(negedge clk);
        cmp("lit term low", {7'd0, o_term_esc}, 8'd0);
        cmp("lit term pulses", 8'(term_pulses - p0), 8'd1);
    endtask

    initial begin
        // Reset with every strobe and the start request active.
        i_escritura = 1; i_dir = 1; i_dat = 1; i_cambio = 1;
        repeat (3) @(negedge clk);
        check_en = 1;
        cmp("rst dir_e", o_dir_e, 8'hFF);
        cmp("rst e_esc", {7'd0, o_e_esc}, 8'd0);
        cmp("rst tr_esc", {7'd0, o_tr_esc}, 8'd0);
        cmp("rst term_esc", {7'd0, o_term_esc}, 8'd0);
        cmp("rst clk_timerE", {7'd0, o_clk_timer_e}, 8'd0);
        i_escritura = 0; i_dir = 0; i_dat = 0; i_cambio = 0;
        @(negedge clk);
        i_reset = 1;
        // Strobes in IDLE are ignored.
        strobe(1, 0, 0);
        cmp("idle strobe", o_dir_e, 8'hFF);

        // Clock pass 12:34:56 25/12/16, Seg changed after start, Escritura re-raised mid-pass.
        exp_seq = '{8'h21, 8'h56, 8'h22, 8'h34, 8'h23, 8'h12, 8'h24, 8'h25,
                    8'h25, 8'h12, 8'h26, 8'h16, 8'hF1, 8'h01};
        start(1);
        i_seg = 8'h59;
        run_pass(7, 0);
        i_seg = 8'h56;

        // Timer pass 00:05:30.
        exp_seq = '{8'h41, 8'h30, 8'h42, 8'h05, 8'h43, 8'h00, 8'hF2, 8'h01,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start(0);
        run_pass(4, 1);

        // Priority, then reset during W_MES.
        start(1);
        strobe(1, 0, 0); cmp("pri seg addr", o_dir_e, 8'h21);
        strobe(0, 0, 1);
        strobe(1, 1, 0); cmp("pri dir>dat", o_dir_e, 8'h22);
        strobe(0, 1, 1); cmp("pri dat>cambio", o_dir_e, 8'h34);
        strobe(1, 0, 0); cmp("pri state held", o_dir_e, 8'h22);
        strobe(0, 0, 1);
        strobe(0, 0, 1);
        strobe(0, 0, 1);
        strobe(1, 0, 0); cmp("pri mes addr", o_dir_e, 8'h25);
        @(negedge clk); i_reset = 0;
        @(negedge clk); i_reset = 1;
        cmp("midrst dir_e", o_dir_e, 8'hFF);
        cmp("midrst e_esc", {7'd0, o_e_esc}, 8'd0);
        strobe(1, 0, 0);
        cmp("midrst idle", o_dir_e, 8'hFF);

        exp_seq = '{8'h21, 8'h56, 8'h22, 8'h34, 8'h23, 8'h12, 8'h24, 8'h25,
                    8'h25, 8'h12, 8'h26, 8'h16, 8'hF1, 8'h01};
        start(1);
        run_pass(7, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
